// File: rtl/axi_ts_pkg.sv
// Shared types and constants for the AXI trigger subsystem source qualifiers.
package axi_ts_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_DELAY   = 3'd2,
        S_FIRE    = 3'd3,
        S_HOLDOFF = 3'd4
    } TS_SRC_STATE_T;

    localparam logic [31:0] SRC_IMMEDIATE = 32'd0;
    localparam logic [31:0] SRC_EXT_BASE  = 32'd1;
    localparam logic [31:0] SRC_RTC       = 32'd16;

    // Events arriving in these states are counted as misses, not queued.
    function automatic logic is_busy_state(input TS_SRC_STATE_T s);
        return (s == S_DELAY) || (s == S_FIRE) || (s == S_HOLDOFF);
    endfunction

endpackage

// File: rtl/axi_ts_sync_edge.sv
// Two-flop synchroniser with registered rising/falling edge flags per bit.
// Flags appear three clk cycles after the pin changes.
module axi_ts_sync_edge #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] rise_o,
    output logic [WIDTH-1:0] fall_o
);

    logic [WIDTH-1:0] meta_q;
    logic [WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] rise_q;
    logic [WIDTH-1:0] fall_q;

    // Synchronise, keep the previous synced sample, and flag any change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            rise_q <= sync_q & ~prev_q;
            fall_q <= ~sync_q & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/axi_ts_trig_src.sv
// Trigger source qualifier: selects software, external pin or RTC match
// events, applies delay and holdoff, and emits a single-cycle pulse.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | disabled; source/slope latched when enable rises
// S_WAIT    | listening for an event from the latched source
// S_DELAY   | counting down the latched delay
// S_FIRE    | trig_pulse high for this one cycle
// S_HOLDOFF | counting down the latched holdoff; events are dropped
module axi_ts_trig_src
    import axi_ts_pkg::*;
#(
    parameter int N_EXT = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N_EXT-1:0] ext_trigger,
    input  logic [31:0]      rtc_sec,
    input  logic [31:0]      rtc_nsec,
    input  logic             ctrl_enable,
    input  logic             ctrl_immediate,
    input  logic [31:0]      ctrl_source,
    input  logic             ctrl_slope,
    input  logic [CNT_W-1:0] ctrl_delay,
    input  logic [CNT_W-1:0] ctrl_holdoff,
    input  logic [31:0]      ctrl_rtc_sec,
    input  logic [31:0]      ctrl_rtc_nsec,
    input  logic             ctrl_clear,
    output logic             trig_pulse,
    output logic             stat_busy,
    output logic [CNT_W-1:0] stat_event_count,
    output logic [CNT_W-1:0] stat_miss_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    TS_SRC_STATE_T    state_q;
    logic [31:0]      src_q;
    logic             slope_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] hold_q;
    logic             rtc_done_q;
    logic             pulse_q;
    logic             busy_q;
    logic [CNT_W-1:0] ev_cnt_q;
    logic [CNT_W-1:0] miss_cnt_q;

    logic [N_EXT-1:0] rise;
    logic [N_EXT-1:0] fall;
    logic             ext_ev;
    logic             rtc_hit;
    logic             ev;
    logic             accept;
    logic             miss;

    axi_ts_sync_edge #(.WIDTH(N_EXT)) u_sync_edge (
        .clk    (clk),
        .rst_n  (rst_n),
        .din_i  (ext_trigger),
        .rise_o (rise),
        .fall_o (fall)
    );

    // Pick the edge flag of the latched external pin with the latched slope.
    always_comb begin
        ext_ev = 1'b0;
        for (int k = 0; k < N_EXT; k++) begin
            if (src_q == SRC_EXT_BASE + 32'(k)) begin
                ext_ev = slope_q ? fall[k] : rise[k];
            end
        end
    end

    assign rtc_hit = {rtc_sec, rtc_nsec} >= {ctrl_rtc_sec, ctrl_rtc_nsec};

    // Unrecognised source codes fall through to the ext match, which never hits.
    assign ev = (src_q == SRC_IMMEDIATE) ? ctrl_immediate :
                (src_q == SRC_RTC)       ? (rtc_hit && !rtc_done_q) :
                                           ext_ev;

    assign accept = (state_q == S_WAIT) && ctrl_enable && ev;
    assign miss   = is_busy_state(state_q) && ev;

    // Main sequencer with registered pulse/busy outputs; one shared down-counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            slope_q    <= 1'b0;
            cnt_q      <= '0;
            hold_q     <= '0;
            rtc_done_q <= 1'b0;
            pulse_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            pulse_q <= 1'b0;
            if (state_q == S_IDLE) begin
                rtc_done_q <= 1'b0;
            end
            if (!ctrl_enable) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE: begin
                        src_q   <= ctrl_source;
                        slope_q <= ctrl_slope;
                        state_q <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (ev) begin
                            hold_q <= ctrl_holdoff;
                            busy_q <= 1'b1;
                            if (src_q == SRC_RTC) begin
                                rtc_done_q <= 1'b1;
                            end
                            if (ctrl_delay != '0) begin
                                cnt_q   <= ctrl_delay;
                                state_q <= S_DELAY;
                            end else begin
                                state_q <= S_FIRE;
                                pulse_q <= 1'b1;
                            end
                        end
                    end
                    S_DELAY: begin
                        if (cnt_q == CNT_ONE) begin
                            state_q <= S_FIRE;
                            pulse_q <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    S_FIRE: begin
                        if (hold_q != '0) begin
                            cnt_q   <= hold_q;
                            state_q <= S_HOLDOFF;
                        end else begin
                            state_q <= S_WAIT;
                            busy_q  <= 1'b0;
                        end
                    end
                    S_HOLDOFF: begin
                        if (cnt_q == CNT_ONE) begin
                            state_q <= S_WAIT;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Saturating status counters; clear takes priority over a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else if (ctrl_clear) begin
            ev_cnt_q   <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (accept && (ev_cnt_q != '1)) begin
                ev_cnt_q <= ev_cnt_q + CNT_ONE;
            end
            if (miss && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_ONE;
            end
        end
    end

    assign trig_pulse       = pulse_q;
    assign stat_busy        = busy_q;
    assign stat_event_count = ev_cnt_q;
    assign stat_miss_count  = miss_cnt_q;

endmodule

// File: tb/tb_axi_ts_trig_src.sv
// Directed and randomized checks for axi_ts_trig_src.
module tb_axi_ts_trig_src;

    localparam int N_EXT = 8;
    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [N_EXT-1:0] ext_trigger;
    logic [31:0]      rtc_sec, rtc_nsec;
    logic             ctrl_enable, ctrl_immediate, ctrl_slope, ctrl_clear;
    logic [31:0]      ctrl_source;
    logic [CNT_W-1:0] ctrl_delay, ctrl_holdoff;
    logic [31:0]      ctrl_rtc_sec, ctrl_rtc_nsec;
    logic             trig_pulse, stat_busy;
    logic [CNT_W-1:0] stat_event_count, stat_miss_count;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    axi_ts_trig_src #(.N_EXT(N_EXT), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ext_trigger      (ext_trigger),
        .rtc_sec          (rtc_sec),
        .rtc_nsec         (rtc_nsec),
        .ctrl_enable      (ctrl_enable),
        .ctrl_immediate   (ctrl_immediate),
        .ctrl_source      (ctrl_source),
        .ctrl_slope       (ctrl_slope),
        .ctrl_delay       (ctrl_delay),
        .ctrl_holdoff     (ctrl_holdoff),
        .ctrl_rtc_sec     (ctrl_rtc_sec),
        .ctrl_rtc_nsec    (ctrl_rtc_nsec),
        .ctrl_clear       (ctrl_clear),
        .trig_pulse       (trig_pulse),
        .stat_busy        (stat_busy),
        .stat_event_count (stat_event_count),
        .stat_miss_count  (stat_miss_count)
    );

    task automatic check(input string tag, input longint obs, input longint exp);
        chk_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Advance n cycles, counting pulse cycles and recording the first one.
    task automatic run_count(input int n, output int npulse, output int first_at);
        npulse   = 0;
        first_at = -1;
        for (int i = 0; i < n; i++) begin
            step();
            if (trig_pulse === 1'b1) begin
                if (npulse == 0) first_at = cyc;
                npulse++;
            end
        end
    endtask

    task automatic go_idle_and_clear();
        ctrl_enable = 1'b0;
        ctrl_clear  = 1'b1;
        step();
        ctrl_clear  = 1'b0;
        step();
    endtask

    task automatic enable_wait();
        ctrl_enable = 1'b1;
        step();
        step();
    endtask

    int np, fa, c0, base, p0, p1;
    longint ns;
    bit exp_p [int];
    int ready, m_ev, m_miss, d, h;

    initial begin
        rst_n = 1'b0;
        ext_trigger = '0;
        rtc_sec = '0; rtc_nsec = '0;
        ctrl_enable = 1'b0; ctrl_immediate = 1'b0; ctrl_slope = 1'b0;
        ctrl_clear = 1'b0; ctrl_source = '0;
        ctrl_delay = '0; ctrl_holdoff = '0;
        ctrl_rtc_sec = '0; ctrl_rtc_nsec = '0;
        step(); step();
        check("reset_pulse", trig_pulse, 0);
        check("reset_busy", stat_busy, 0);
        check("reset_evcnt", stat_event_count, 0);
        check("reset_misscnt", stat_miss_count, 0);
        rst_n = 1'b1;
        step();

        // Rising edge on ext_trigger[2], no delay: pulse 4 cycles after pin edge.
        ctrl_source = 32'd3;
        enable_wait();
        run_count(4, np, fa);
        check("ext_no_spurious", np, 0);
        c0 = cyc;
        ext_trigger[2] = 1'b1;
        run_count(10, np, fa);
        check("ext_rise_pulse_at", fa - c0, 4);
        check("ext_rise_pulse_width", np, 1);
        check("ext_rise_evcnt", stat_event_count, 1);
        ext_trigger[2] = 1'b0;
        run_count(10, np, fa);
        check("ext_fall_ignored", np, 0);

        // Immediate source with delay 5 and holdoff 10.
        go_idle_and_clear();
        ctrl_source = 32'd0; ctrl_delay = 8'd5; ctrl_holdoff = 8'd10;
        enable_wait();
        base = cyc; p0 = -1; p1 = -1;
        for (int rel = 0; rel < 36; rel++) begin
            ctrl_immediate = (rel == 0) || (rel == 10) || (rel == 17);
            if (rel == 3) check("imm_busy_in_delay", stat_busy, 1);
            step();
            if (trig_pulse === 1'b1) begin
                if (p0 < 0) p0 = cyc - base;
                else if (p1 < 0) p1 = cyc - base;
            end
        end
        ctrl_immediate = 1'b0;
        check("imm_pulse0_at", p0, 6);
        check("imm_pulse1_at", p1, 23);
        check("imm_evcnt", stat_event_count, 2);
        check("imm_misscnt", stat_miss_count, 1);

        // RTC match at 5.000000000, ramp through it.
        go_idle_and_clear();
        ctrl_source = 32'd16; ctrl_delay = '0; ctrl_holdoff = '0;
        ctrl_rtc_sec = 32'd5; ctrl_rtc_nsec = 32'd0;
        rtc_sec = 32'd4; rtc_nsec = 32'd999999990;
        enable_wait();
        base = cyc; p0 = -1; np = 0;
        for (int k = 0; k < 35; k++) begin
            ns = 64'd4999999990 + longint'((k < 20) ? k : 20);
            rtc_sec  = 32'(ns / 1000000000);
            rtc_nsec = 32'(ns % 1000000000);
            step();
            if (trig_pulse === 1'b1) begin
                if (p0 < 0) p0 = cyc - base;
                np++;
            end
        end
        check("rtc_pulse_at", p0, 11);
        check("rtc_single_pulse", np, 1);
        ctrl_enable = 1'b0;
        step(); step();
        ctrl_enable = 1'b1;
        run_count(8, np, fa);
        check("rtc_rearm_pulse", np, 1);

        // Enable dropped mid-delay: pulse discarded.
        go_idle_and_clear();
        ctrl_source = 32'd0; ctrl_delay = 8'd20; ctrl_holdoff = '0;
        enable_wait();
        ctrl_immediate = 1'b1;
        step();
        ctrl_immediate = 1'b0;
        step(); step(); step(); step();
        check("abort_busy_before", stat_busy, 1);
        ctrl_enable = 1'b0;
        step();
        check("abort_busy_after", stat_busy, 0);
        check("abort_no_pulse_now", trig_pulse, 0);
        run_count(30, np, fa);
        check("abort_no_pulse", np, 0);

        // Falling-edge qualification on ext_trigger[0], enabled while pin high.
        go_idle_and_clear();
        ext_trigger[0] = 1'b1;
        step(); step(); step(); step(); step();
        ctrl_source = 32'd1; ctrl_slope = 1'b1; ctrl_delay = '0;
        enable_wait();
        run_count(8, np, fa);
        check("slope_no_spurious", np, 0);
        c0 = cyc;
        ext_trigger[0] = 1'b0;
        run_count(10, np, fa);
        check("slope_fall_pulse_at", fa - c0, 4);
        ext_trigger[0] = 1'b1;
        run_count(10, np, fa);
        check("slope_rise_ignored", np, 0);
        c0 = cyc;
        ext_trigger[0] = 1'b0;
        run_count(10, np, fa);
        check("slope_fall2_pulse_at", fa - c0, 4);
        check("slope_evcnt", stat_event_count, 2);
        ctrl_slope = 1'b0;

        // Async reset in holdoff, then clear coinciding with a miss.
        go_idle_and_clear();
        ctrl_source = 32'd0; ctrl_delay = '0; ctrl_holdoff = 8'd30;
        enable_wait();
        ctrl_immediate = 1'b1;
        step();
        ctrl_immediate = 1'b0;
        step(); step();
        check("holdoff_busy", stat_busy, 1);
        check("holdoff_evcnt", stat_event_count, 1);
        #3;
        rst_n = 1'b0;
        #1;
        check("async_rst_busy", stat_busy, 0);
        check("async_rst_pulse", trig_pulse, 0);
        check("async_rst_evcnt", stat_event_count, 0);
        ctrl_enable = 1'b0;
        step(); step();
        rst_n = 1'b1;
        step();
        ctrl_delay = 8'd5; ctrl_holdoff = '0;
        enable_wait();
        ctrl_immediate = 1'b1;
        step();
        check("clr_pre_evcnt", stat_event_count, 1);
        ctrl_clear = 1'b1;
        step();
        ctrl_immediate = 1'b0;
        ctrl_clear = 1'b0;
        check("clr_evcnt", stat_event_count, 0);
        check("clr_misscnt", stat_miss_count, 0);

        // Miss counter saturation with immediate held high.
        go_idle_and_clear();
        ctrl_delay = '0; ctrl_holdoff = 8'd200;
        enable_wait();
        ctrl_immediate = 1'b1;
        for (int i = 0; i < 600; i++) step();
        ctrl_immediate = 1'b0;
        check("sat_evcnt", stat_event_count, (600 + 201) / 202);
        check("sat_misscnt", stat_miss_count, 255);

        // Randomized immediate events against a timeline model.
        go_idle_and_clear();
        ctrl_source = 32'd0;
        ctrl_enable = 1'b1;
        step();
        ready = cyc; m_ev = 0; m_miss = 0;
        for (int i = 0; i < 1200; i++) begin
            check("rnd_pulse", trig_pulse, exp_p.exists(cyc) ? 1 : 0);
            d = $urandom_range(0, 6);
            h = $urandom_range(0, 6);
            ctrl_delay     = 8'(d);
            ctrl_holdoff   = 8'(h);
            ctrl_immediate = ($urandom_range(0, 3) == 0);
            if (ctrl_immediate) begin
                if (cyc >= ready) begin
                    exp_p[cyc + 1 + d] = 1'b1;
                    ready = cyc + 1 + d + 1 + h;
                    if (m_ev < 255) m_ev++;
                end else if (m_miss < 255) begin
                    m_miss++;
                end
            end
            step();
        end
        ctrl_immediate = 1'b0;
        for (int i = 0; i < 20; i++) begin
            check("rnd_drain_pulse", trig_pulse, exp_p.exists(cyc) ? 1 : 0);
            step();
        end
        check("rnd_evcnt", stat_event_count, m_ev);
        check("rnd_misscnt", stat_miss_count, m_miss);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/axi_ts_trig_src.md
# axi_ts_trig_src

Trigger source qualifier for the AXI Trigger Subsystem. It selects one event source: software immediate, one of the external trigger pins, or an RTC time match. The selected source is edge-detected, then a programmable delay and holdoff are applied before a single-cycle pulse is emitted. Two instances sit in front of the trigger-subsystem state machine, one driving its arm input and one driving its trigger input.

## Interface
Parameters:
- N_EXT, 8, number of external trigger pins
- CNT_W, 32, width of delay/holdoff counters and status counters

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset; asynchronous, active-low
- ext_trigger  in  N_EXT  asynchronous external trigger pins
- rtc_sec  in  32  RTC seconds, clk domain
- rtc_nsec  in  32  RTC nanoseconds, clk domain
- ctrl_enable  in  1  level; unit listens while high
- ctrl_immediate  in  1  one-cycle software event
- ctrl_source  in  32  0 = immediate, 1..N_EXT = ext_trigger[k-1], 16 = RTC match, any other value = none
- ctrl_slope  in  1  0 = rising edge, 1 = falling edge (ext sources only)
- ctrl_delay  in  CNT_W  cycles from qualified event to pulse
- ctrl_holdoff  in  CNT_W  cycles after the pulse during which events are ignored
- ctrl_rtc_sec / ctrl_rtc_nsec  in  32 each  RTC match time
- ctrl_clear  in  1  one-cycle clear of status counters
- trig_pulse  out  1  one-cycle qualified trigger
- stat_busy  out  1  high in S_DELAY, S_FIRE, S_HOLDOFF
- stat_event_count  out  CNT_W  accepted events
- stat_miss_count  out  CNT_W  events dropped in S_DELAY/S_FIRE/S_HOLDOFF

## Operation
- Reset: state S_IDLE; trig_pulse, stat_busy, both counters 0; sync flops 0; rtc_done 0.
- Ext path: each pin passes 2-FF sync, then a registered edge flag compares the current synced sample to the previous one. The edge pipeline runs regardless of state, so enabling never produces a spurious edge.
- Event from the immediate source = ctrl_immediate.
- RTC event = {rtc_sec,rtc_nsec} >= {ctrl_rtc_sec,ctrl_rtc_nsec} (64-bit unsigned compare) and !rtc_done. rtc_done is set on RTC acceptance and cleared in S_IDLE. The RTC source therefore fires once per enable period.
- ctrl_source and ctrl_slope are latched on S_IDLE→S_WAIT.
- ctrl_delay and ctrl_holdoff are latched at event acceptance.
- FSM:
  - S_IDLE → S_WAIT when ctrl_enable.
  - S_WAIT → S_DELAY on event when latched delay > 0; S_WAIT → S_FIRE on event when latched delay = 0.
  - S_DELAY: count down; → S_FIRE when count reaches 1.
  - S_FIRE: trig_pulse = 1 for exactly one cycle; → S_HOLDOFF when holdoff > 0, else → S_WAIT.
  - S_HOLDOFF: count down; → S_WAIT when count reaches 1.
- ctrl_enable low in any state → S_IDLE next cycle. Any pending pulse is discarded and no pulse is emitted that cycle.
- Event while busy: stat_miss_count increments, and the event is not queued.
- Counters saturate at 2^CNT_W−1.
- ctrl_clear zeroes both counters. If ctrl_clear coincides with an increment, the counter becomes 0.
- Source code "none": no events are ever accepted.

## Timing
- Ext pin edge to edge flag: 3 clk cycles.
- Edge flag or ctrl_immediate or RTC compare true at cycle E, delay D: trig_pulse high at E+1+D.
- After a pulse at cycle P with holdoff H: next event accepted no earlier than cycle P+1+H.
- Config changes in S_WAIT affect delay/holdoff of the next event only. Source/slope changes need an enable toggle.

## Structure
- Shared package axi_ts_pkg holds:
  - state enum TS_SRC_STATE_T (S_IDLE, S_WAIT, S_DELAY, S_FIRE, S_HOLDOFF)
  - source constants SRC_IMMEDIATE=0, SRC_EXT_BASE=1, SRC_RTC=16
- Sub-module axi_ts_sync_edge: parameterised width; 2-FF sync plus rising/falling edge flags per bit; async active-low reset.
- Top level: FSM, one shared down-counter for delay/holdoff, RTC comparator, status counters. Target size is 150–250 lines.

## Test plan
- Source=3, slope=0, delay=0, holdoff=0: rising edge on ext_trigger[2] → trig_pulse one cycle, 4 cycles after the pin edge; stat_event_count=1.
- Source=0, delay=5, holdoff=10: ctrl_immediate at cycle 100 → pulse at 106; second immediate at 110 → dropped, stat_miss_count=1; third at 117 → accepted, pulse at 123.
- Source=16, match at sec=5, nsec=0: RTC ramps through 4.999999990 to 5.000000010 → exactly one pulse, one cycle after the compare becomes true. No second pulse until enable is toggled.
- Delay=20: drop ctrl_enable 5 cycles after the event → no pulse, stat_busy falls next cycle, state S_IDLE.
- Slope=1 on ext_trigger[0] with a glitch-free toggle pattern 0→1→0 → pulse only for the 1→0 edge; enable raised while the pin is high → no spurious event.
- rst_n asserted mid S_HOLDOFF → all outputs 0 asynchronously; after release, ctrl_clear with simultaneous miss → counters read 0.
